// File: rtl/morse_tx_scheduler_pkg.sv
// morse_tx_scheduler_pkg
//   Shared definitions for the Morse transmit path. Holds the ASCII constants
//   the scheduler treats specially, the scheduler state encodings, the gap
//   unit counts shared with morse_generator, and the newline mapping helper.
//   No ports; imported by the scheduler top and its FIFO.

package morse_tx_scheduler_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // Standard Morse spacing in units. The generator always emits one unit of
  // silence after each character, so the scheduler adds the remainder of the
  // letter gap itself.
  localparam int GEN_TRAILING_UNITS       = 1;
  localparam int LETTER_GAP_TOTAL_UNITS   = 3;
  localparam int WORD_GAP_TOTAL_UNITS     = 7;
  localparam int LETTER_GAP_UNITS_DEFAULT = LETTER_GAP_TOTAL_UNITS - GEN_TRAILING_UNITS;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_GAP       = 3'd4,
    ST_DRAIN     = 3'd5
  } sched_state_t;

  // CR and LF become a word space when newline mapping is enabled.
  function automatic logic [7:0] map_char(input logic [7:0] c, input bit map_newline);
    if (map_newline && ((c == ASCII_CR) || (c == ASCII_LF))) begin
      return ASCII_SPACE;
    end
    return c;
  endfunction

endpackage

// File: rtl/morse_tx_scheduler_fifo.sv
// morse_tx_scheduler_fifo
//   Pointer-based synchronous character FIFO with show-ahead head output and
//   a flush that wins over a simultaneous push or pop.
// Ports:
//   clk_i, reset_i   clock, asynchronous active-high reset
//   flush            empties the FIFO at the next edge
//   push, push_data  write request and data (ignored when full or flushing)
//   pop              read request (ignored when empty or flushing)
//   head             entry at the read pointer, valid while !empty
//   count            occupancy, 0..DEPTH
//   full, empty      occupancy flags

module morse_tx_scheduler_fifo
  import morse_tx_scheduler_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  // DEPTH is a power of two, so the count reaches DEPTH exactly when its top
  // bit is set.
  assign full  = count_reg[AW];
  assign empty = (count_reg == '0);

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Show-ahead read so the scheduler can register the head in the pop cycle.
  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/morse_tx_scheduler.sv
// morse_tx_scheduler
//   Buffers ASCII bytes from uart_rx, feeds them one at a time into
//   morse_generator over its level start/done handshake, and appends the
//   inter-letter silence the generator does not produce.
// Ports:
//   clk_i, reset_i  clock, asynchronous active-high reset
//   in_data_i       ASCII byte from uart_rx
//   in_valid_i      byte valid; accepted when in_valid_i && in_ready_o
//   in_ready_o      FIFO not full
//   abort_i         1-cycle pulse: flush FIFO, stop after the current character
//   gen_ascii_o     character to morse_generator, stable while gen_start_o=1
//   gen_start_o     level start to morse_generator
//   gen_done_i      done from morse_generator
//   char_done_o     1-cycle pulse when a character and its gap are complete
//   busy_o          FSM active or FIFO non-empty
//   fifo_count_o    FIFO occupancy

module morse_tx_scheduler
  import morse_tx_scheduler_pkg::*;
#(
  parameter int MORSE_CYCLES     = 10,
  parameter int FIFO_DEPTH       = 16,
  parameter int LETTER_GAP_UNITS = LETTER_GAP_UNITS_DEFAULT,
  parameter int MAP_NEWLINE      = 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [7:0]                  in_data_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic                        abort_i,
  output logic [7:0]                  gen_ascii_o,
  output logic                        gen_start_o,
  input  logic                        gen_done_i,
  output logic                        char_done_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

  localparam logic [31:0] GAP_CYCLES  = 32'(LETTER_GAP_UNITS * MORSE_CYCLES);
  localparam bit          GAP_ENABLED = (GAP_CYCLES != 32'd0);

  sched_state_t state_reg;
  logic [7:0]   gen_ascii_reg;
  logic         gen_start_reg;
  logic         char_done_reg;
  logic [31:0]  gap_cnt_reg;
  logic         aborted_reg;

  logic         fifo_pop;
  logic [7:0]   fifo_head;
  logic         fifo_full;
  logic         fifo_empty;

  // An abort flushes the FIFO, so no pop may be taken in the same cycle.
  assign fifo_pop = (state_reg == ST_IDLE) && !fifo_empty && !abort_i;

  morse_tx_scheduler_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .flush     (abort_i),
    .push      (in_valid_i),
    .push_data (in_data_i),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count_o),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg     <= ST_IDLE;
      gen_ascii_reg <= 8'h00;
      gen_start_reg <= 1'b0;
      char_done_reg <= 1'b0;
      gap_cnt_reg   <= 32'd0;
      aborted_reg   <= 1'b0;
    end else begin
      char_done_reg <= 1'b0;
      unique case (state_reg)
        ST_IDLE: begin
          if (!abort_i && !fifo_empty) begin
            gen_ascii_reg <= map_char(fifo_head, MAP_NEWLINE != 0);
            state_reg     <= ST_START;
          end
        end

        ST_START: begin
          // Start has not been raised yet, so the generator has seen nothing
          // of this character; an abort here can return straight to IDLE
          // instead of waiting in DRAIN for a done that would never come.
          if (abort_i) begin
            state_reg <= ST_IDLE;
          end else begin
            gen_start_reg <= 1'b1;
            state_reg     <= ST_WAIT_DONE;
          end
        end

        ST_WAIT_DONE: begin
          if (gen_done_i) begin
            gen_start_reg <= 1'b0;
            aborted_reg   <= abort_i;
            state_reg     <= ST_RELEASE;
          end else if (abort_i) begin
            // The generator keeps going to the end of the character; with
            // start low it then drops back to idle on its own.
            gen_start_reg <= 1'b0;
            aborted_reg   <= 1'b1;
            state_reg     <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (gen_done_i) begin
            state_reg <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          // done falling means the generator has returned to idle.
          if (!gen_done_i) begin
            aborted_reg <= 1'b0;
            if (aborted_reg || abort_i) begin
              state_reg <= ST_IDLE;
            end else if ((gen_ascii_reg == ASCII_SPACE) || !GAP_ENABLED) begin
              char_done_reg <= 1'b1;
              state_reg     <= ST_IDLE;
            end else begin
              gap_cnt_reg <= 32'd0;
              state_reg   <= ST_GAP;
            end
          end else if (abort_i) begin
            aborted_reg <= 1'b1;
          end
        end

        ST_GAP: begin
          if (abort_i) begin
            state_reg <= ST_IDLE;
          end else if ((gap_cnt_reg + 32'd1) == GAP_CYCLES) begin
            char_done_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 32'd1;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign gen_ascii_o = gen_ascii_reg;
  assign gen_start_o = gen_start_reg;
  assign char_done_o = char_done_reg;
  assign in_ready_o  = !fifo_full;
  assign busy_o      = (state_reg != ST_IDLE) || !fifo_empty;

endmodule
